// File: rtl/rk_key_sequencer.sv
// Radio-86RK/Apogee keyboard matrix owner: arbitrates live PS/2 key events against a
// ROM-driven auto-type script, buffering live events in a small FIFO while a script runs.
module rk_key_sequencer #(
   parameter int unsigned STEP_DIV  = 3500000,
   parameter int unsigned SCRIPT_AW = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 kbd_valid,
   input  logic                 kbd_press,
   input  logic [3:0]           kbd_row,
   input  logic [2:0]           kbd_col,
   input  logic                 start,
   input  logic [SCRIPT_AW-1:0] start_addr,
   output logic [SCRIPT_AW-1:0] rom_addr,
   input  logic [7:0]           rom_data,
   input  logic [7:0]           addr,
   output logic [7:0]           odata,
   output logic [2:0]           shift,
   output logic                 busy,
   output logic                 ovf
);

   localparam int unsigned CNT_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int unsigned ROWS   = 11;
   localparam int unsigned FIFO_D = 4;

   typedef struct packed {
      logic       press;
      logic [3:0] row;
      logic [2:0] col;
   } key_ev_t;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_WAIT} state_t;

   state_t                       state_q, state_d;
   logic [SCRIPT_AW-1:0]         pc_q, pc_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic                         busy_q, busy_d;
   logic                         ovf_q, ovf_d;
   logic [ROWS-1:0][7:0]         mat_q, mat_d;
   key_ev_t [FIFO_D-1:0]         fifo_q;
   logic [1:0]                   rd_q, rd_d;
   logic [2:0]                   fcnt_q, fcnt_d;

   key_ev_t    live_ev;
   key_ev_t    app_ev;
   logic       app_en;
   logic       push_req;
   logic       push_ok;
   logic       pop;
   logic       fifo_full;
   logic       fifo_empty;
   logic [1:0] wr_idx;

   assign live_ev    = {kbd_press, kbd_row, kbd_col};
   assign fifo_full  = (fcnt_q == 3'd4);
   assign fifo_empty = (fcnt_q == 3'd0);
   assign wr_idx     = rd_q + fcnt_q[1:0];

   // Sequencer, live-path arbitration and matrix update
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      ovf_d    = ovf_q;
      mat_d    = mat_q;
      push_req = 1'b0;
      pop      = 1'b0;
      app_en   = 1'b0;
      app_ev   = live_ev;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               pc_d     = start_addr;
               mat_d    = '0;
               busy_d   = 1'b1;
               state_d  = S_FETCH;
               push_req = kbd_valid;
            end else if (!fifo_empty) begin
               pop      = 1'b1;
               app_en   = 1'b1;
               app_ev   = fifo_q[rd_q];
               push_req = kbd_valid;
            end else if (kbd_valid) begin
               app_en   = 1'b1;
            end
         end
         S_FETCH: begin
            push_req = kbd_valid;
            state_d  = S_EXEC;
         end
         S_EXEC: begin
            push_req = kbd_valid;
            if (rom_data == 8'hFF) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               if (rom_data != 8'h00) begin
                  app_en = 1'b1;
                  app_ev = {rom_data[7], rom_data[3:0], rom_data[6:4]};
               end
               pc_d    = pc_q + SCRIPT_AW'(1);
               cnt_d   = CNT_W'(STEP_DIV - 1);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            push_req = kbd_valid;
            if (cnt_q == '0) begin
               state_d = S_FETCH;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Rows 11-15 do not exist; such events are silently discarded
      if (app_en && (app_ev.row <= 4'd10)) begin
         mat_d[app_ev.row][app_ev.col] = app_ev.press;
      end

      push_ok = push_req && !fifo_full;
      if (push_req && fifo_full) begin
         ovf_d = 1'b1;
      end
      rd_d   = rd_q + 2'(pop);
      fcnt_d = fcnt_q + 3'(push_ok) - 3'(pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
         mat_q   <= '0;
         fifo_q  <= '0;
         rd_q    <= '0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
         mat_q   <= mat_d;
         rd_q    <= rd_d;
         fcnt_q  <= fcnt_d;
         if (push_ok) begin
            fifo_q[wr_idx] <= live_ev;
         end
      end
   end

   // CPU-side row scan
   always_comb begin
      odata = '0;
      for (int i = 0; i < 8; i++) begin
         if (addr[i]) begin
            odata = odata | mat_q[i];
         end
      end
   end

   assign shift    = mat_q[8][2:0];
   assign busy     = busy_q;
   assign ovf      = ovf_q;
   assign rom_addr = pc_q;

endmodule

// File: tb/tb_rk_key_sequencer.sv
// Bench for rk_key_sequencer: directed scenarios plus random traffic, every cycle checked
// against an event-level model of the matrix, live queue and script player.
module tb_rk_key_sequencer;

   localparam int unsigned STEP = 4;
   localparam int unsigned AW   = 6;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          kbd_valid = 1'b0;
   logic          kbd_press = 1'b0;
   logic [3:0]    kbd_row = '0;
   logic [2:0]    kbd_col = '0;
   logic          start = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [AW-1:0] rom_addr;
   logic [7:0]    rom_data;
   logic [7:0]    addr = '0;
   logic [7:0]    odata;
   logic [2:0]    shift;
   logic          busy;
   logic          ovf;

   logic [7:0]    rom [64];

   always #5 clk = ~clk;

   always_ff @(posedge clk) rom_data <= rom[rom_addr];

   rk_key_sequencer #(.STEP_DIV(STEP), .SCRIPT_AW(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .kbd_valid  (kbd_valid),
      .kbd_press  (kbd_press),
      .kbd_row    (kbd_row),
      .kbd_col    (kbd_col),
      .start      (start),
      .start_addr (start_addr),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .addr       (addr),
      .odata      (odata),
      .shift      (shift),
      .busy       (busy),
      .ovf        (ovf)
   );

   typedef struct packed {
      bit       press;
      bit [3:0] row;
      bit [2:0] col;
   } ev_t;

   // Reference model: key matrix, live queue, script player with a step countdown
   bit [7:0]    m_mat [11];
   ev_t         m_q [$];
   bit          m_busy;
   bit          m_ovf;
   int          m_left;
   int unsigned m_pc;

   int vectors = 0;
   int miscompares = 0;

   function automatic void m_apply(ev_t e);
      if (e.row <= 4'd10) m_mat[e.row][e.col] = e.press;
   endfunction

   function automatic void m_push(ev_t e);
      if (m_q.size() >= 4) m_ovf = 1'b1;
      else m_q.push_back(e);
   endfunction

   function automatic void m_reset();
      foreach (m_mat[i]) m_mat[i] = 8'h00;
      m_q.delete();
      m_busy = 1'b0;
      m_ovf  = 1'b0;
      m_left = 0;
      m_pc   = 0;
   endfunction

   function automatic void m_clock();
      ev_t     live;
      ev_t     head;
      bit      was_full;
      bit [7:0] b;
      live = {kbd_press, kbd_row, kbd_col};
      if (!m_busy) begin
         if (start) begin
            m_busy = 1'b1;
            m_pc   = start_addr;
            foreach (m_mat[i]) m_mat[i] = 8'h00;
            m_left = 2;
            if (kbd_valid) m_push(live);
         end else if (m_q.size() > 0) begin
            was_full = (m_q.size() == 4);
            head = m_q.pop_front();
            m_apply(head);
            if (kbd_valid) begin
               if (was_full) m_ovf = 1'b1;
               else m_q.push_back(live);
            end
         end else if (kbd_valid) begin
            m_apply(live);
         end
      end else begin
         if (kbd_valid) m_push(live);
         m_left = m_left - 1;
         if (m_left == 0) begin
            b = rom[m_pc];
            if (b == 8'hFF) begin
               m_busy = 1'b0;
            end else begin
               if (b != 8'h00) m_apply({b[7], b[3:0], b[6:4]});
               m_pc   = (m_pc + 1) % 64;
               m_left = int'(STEP) + 2;
            end
         end
      end
   endfunction

   function automatic logic [7:0] exp_odata();
      logic [7:0] r = 8'h00;
      for (int i = 0; i < 8; i++) if (addr[i]) r = r | m_mat[i];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("odata", 32'(odata), 32'(exp_odata()));
      chk("shift", 32'(shift), 32'(m_mat[8][2:0]));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("rom_addr", 32'(rom_addr), 32'(m_pc));
   endtask

   task automatic step();
      @(posedge clk);
      if (!reset) m_clock();
      #1;
      check_all();
   endtask

   task automatic key(input bit press, input int row, input int col);
      kbd_valid = 1'b1;
      kbd_press = press;
      kbd_row   = 4'(row);
      kbd_col   = 3'(col);
      step();
      kbd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max_cycles);
      int n = 0;
      while (busy !== 1'b0 && n < max_cycles) begin
         step();
         n++;
      end
      chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   int          k;
   int          nb;
   int          set_k;
   int          clr_k;
   int unsigned seq [$];

   initial begin
      foreach (rom[i]) rom[i] = 8'h00;
      m_reset();

      // Reset state
      addr = 8'hFF;
      repeat (2) @(posedge clk);
      #1;
      check_all();
      chk("reset_odata", 32'(odata), 32'h00);
      chk("reset_rom_addr", 32'(rom_addr), 32'd0);
      reset = 1'b0;

      // Live direct press/release
      addr = 8'h10;
      key(1'b1, 4, 1);
      chk("live_press", 32'(odata), 32'h02);
      key(1'b0, 4, 1);
      chk("live_release", 32'(odata), 32'h00);

      // Script {A6,26,FF} at 5
      rom[5] = 8'hA6; rom[6] = 8'h26; rom[7] = 8'hFF;
      addr = 8'h40;
      start = 1'b1; start_addr = 6'd5;
      step();
      start = 1'b0;
      chk("start_rom_addr", 32'(rom_addr), 32'd5);
      k = 0; nb = (busy === 1'b1) ? 1 : 0;
      seq.delete(); seq.push_back(32'(rom_addr));
      set_k = -1; clr_k = -1;
      while (busy === 1'b1 && k < 40) begin
         step();
         k++;
         if (busy === 1'b1) nb++;
         if (32'(rom_addr) != seq[$]) seq.push_back(32'(rom_addr));
         if (odata[2] === 1'b1 && set_k < 0) set_k = k;
         if (odata[2] === 1'b0 && set_k >= 0 && clr_k < 0) clr_k = k;
      end
      chk("busy_cycles", 32'(nb), 32'd14);
      chk("row6_set_at", 32'(set_k), 32'd2);
      chk("row6_held", 32'(clr_k - set_k), 32'd6);
      chk("addr_seq_len", 32'(seq.size()), 32'd3);
      if (seq.size() == 3) begin
         chk("addr_seq0", seq[0], 32'd5);
         chk("addr_seq1", seq[1], 32'd6);
         chk("addr_seq2", seq[2], 32'd7);
      end

      // Overflow: five presses while busy, four replayed in order
      addr = 8'h1F;
      start = 1'b1; start_addr = 6'd5;
      step();
      start = 1'b0;
      for (int r = 0; r < 5; r++) key(1'b1, r, r);
      chk("ovf_set", 32'(ovf), 32'd1);
      wait_idle(40);
      chk("drain_none", 32'(odata), 32'h00);
      step(); chk("drain_1", 32'(odata), 32'h01);
      step(); chk("drain_2", 32'(odata), 32'h03);
      step(); chk("drain_3", 32'(odata), 32'h07);
      step(); chk("drain_4", 32'(odata), 32'h0F);
      step(); chk("row4_never", 32'(odata), 32'h0F);

      // start while busy is ignored
      start = 1'b1; start_addr = 6'd5;
      step();
      start_addr = 6'd20;
      step();
      start = 1'b0;
      chk("start_ignored", 32'(rom_addr), 32'd5);
      wait_idle(40);

      // start with kbd_valid in IDLE: script wins, event replayed after
      start = 1'b1; start_addr = 6'd5;
      key(1'b1, 8, 1);
      start = 1'b0;
      chk("shift_during", 32'(shift), 32'd0);
      wait_idle(40);
      step();
      chk("shift_after", 32'(shift), 32'd2);

      // pc wrap 63 -> 0
      rom[63] = 8'h00; rom[0] = 8'hFF;
      start = 1'b1; start_addr = 6'd63;
      step();
      start = 1'b0;
      chk("wrap_first", 32'(rom_addr), 32'd63);
      nb = 1; k = 0;
      while (busy === 1'b1 && k < 40) begin
         step();
         k++;
         if (busy === 1'b1) nb++;
      end
      chk("wrap_second", 32'(rom_addr), 32'd0);
      chk("wrap_busy", 32'(nb), 32'd8);

      // Reset during WAIT with keys held and a queued event
      addr = 8'hFF;
      start = 1'b1; start_addr = 6'd5;
      step();
      start = 1'b0;
      key(1'b1, 1, 3);
      step(); step();
      reset = 1'b1;
      #1;
      m_reset();
      check_all();
      chk("rst_odata", 32'(odata), 32'h00);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      step();
      reset = 1'b0;
      step();
      chk("rst_fifo_empty", 32'(odata), 32'h00);
      start = 1'b1; start_addr = 6'd5;
      step();
      start = 1'b0;
      wait_idle(40);

      // Random traffic
      foreach (rom[i]) rom[i] = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
      for (int c = 0; c < 1500; c++) begin
         kbd_valid  = ($urandom_range(0, 2) == 0);
         kbd_press  = 1'($urandom);
         kbd_row    = 4'($urandom);
         kbd_col    = 3'($urandom);
         start      = ($urandom_range(0, 30) == 0);
         start_addr = 6'($urandom);
         addr       = 8'($urandom);
         step();
      end
      kbd_valid = 1'b0;
      start = 1'b0;
      wait_idle(600);
      repeat (6) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rk_key_sequencer.md
# rk_key_sequencer

Keyboard-matrix controller for the Radio-86RK/Apogee keyboard path. It owns the 11x8 key matrix and arbitrates between two requesters: live key events from the PS/2 decoder, and a scripted auto-type player that walks a byte script in an external synchronous ROM with a programmable inter-step delay. Live events that arrive while a script runs are buffered in a 4-deep FIFO and replayed once the script ends. The CPU-side row scan and the shift outputs are served directly from the matrix.

## Interface
- STEP_DIV, 3500000: clk cycles spent in WAIT after each executed script byte; legal range is ≥1.
- SCRIPT_AW, 6: script ROM address width.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-high.
- kbd_valid  in  1  one-cycle strobe for a live key event.
- kbd_press  in  1  1 = press, 0 = release.
- kbd_row  in  4  matrix row, 0-10.
- kbd_col  in  3  matrix column.
- start  in  1  one-cycle pulse that starts a script.
- start_addr  in  SCRIPT_AW  first script byte.
- rom_addr  out  SCRIPT_AW  script ROM address; ROM is synchronous with 1-cycle latency.
- rom_data  in  8  script byte.
- addr  in  8  row-select mask from the PPI.
- odata  out  8  OR of matrix rows 0-7 whose addr bit is 1; combinational.
- shift  out  3  matrix row 8, bits 2:0; combinational.
- busy  out  1  script running.
- ovf  out  1  sticky live-FIFO overflow flag.

## Operation
- Script byte encoding:
  - 0xFF: end of script.
  - 0x00: no-op step.
  - Anything else: bit7 = press/release, bits6:4 = column, bits3:0 = row.
  - Row >10 is ignored; the step still consumes time.
- States: IDLE, FETCH, EXEC, WAIT.
- IDLE, start=1: pc<=start_addr, all 11 rows cleared, busy<=1, go FETCH. start is ignored in every other state.
- FETCH: rom_addr=pc; go EXEC.
- EXEC, rom_data=0xFF: busy<=0, go IDLE.
- EXEC, any other byte:
  - Apply the byte if it is non-zero and its row is valid.
  - pc<=pc+1; pc wraps from 2^SCRIPT_AW-1 to 0.
  - cnt<=STEP_DIV-1, go WAIT.
- WAIT: cnt decrements; at cnt==0, go FETCH.
- Live path:
  - Event applied directly when state is IDLE, FIFO is empty and start=0.
  - Otherwise the event is pushed into the 4-entry FIFO.
  - Push when full: event dropped, ovf<=1. ovf is cleared only by reset.
- FIFO drain: in IDLE with start=0, one entry is popped and applied per cycle. A push in the same cycle enqueues behind the existing entries, so order is preserved.
- start and kbd_valid in the same IDLE cycle: start wins and the event is pushed.
- Live events with row >10 are accepted into the FIFO and ignored when applied.
- Row clearing by start does not touch FIFO contents.
- Reset values:
  - Matrix all 0, so odata=0 and shift=0.
  - FIFO empty, ovf=0, busy=0, state IDLE, pc=0, rom_addr=0, cnt=0.
- Reset asserted mid-script aborts immediately; nothing is resumed.

## Timing
- Live direct path: event sampled at edge E; matrix bit updated at E; odata reflects it in the cycle after E.
- Script start sampled at edge E0:
  - busy=1 and rom_addr=start_addr after E0.
  - ROM data valid after E1.
  - Matrix updated at E2.
- Each non-terminal script byte occupies STEP_DIV+2 cycles (FETCH + EXEC + STEP_DIV WAIT cycles).
- End byte: busy falls at the EXEC edge. The first FIFO pop happens on the following edge.
- FIFO drain rate: 1 event/cycle; 4 queued events are fully applied 4 cycles after busy falls.
- rom_addr holds pc at all times; pc changes only at EXEC edges and at start.

## Test plan
- Reset, then live press row 4 col 1, addr=0x10 → odata=0x02 one cycle later; release → odata=0x00.
- STEP_DIV=4, script {0xA6,0x26,0xFF} at addr 5:
  - Row 6 bit 2 set at E2, cleared 6 cycles later.
  - busy high for exactly 14 cycles.
  - rom_addr sequence 5,6,7.
- Script running; 5 live presses on rows 0-4 → ovf=1; rows 0-3 applied in order on 4 consecutive cycles after busy falls; row 4 never set.
- start while busy → ignored, pc unchanged. start together with kbd_valid in IDLE → script starts, event applied after script end.
- SCRIPT_AW=2, start_addr=3, script {3:0x00, 0:0xFF} → rom_addr 3 then 0; busy drops after 2 steps.
- Assert reset during WAIT with keys held → matrix, FIFO, busy and ovf all 0 immediately; a new start runs normally.
